id_stage_pipe: RTL and testbench

- Parametrised decode stage for the in-order RISC-V core.
- Replaces the flat combinational decode with a registered ID/EX boundary. Combines control decode, immediate generation and an internal register file.
- Adds: valid/ready handshake on both sides, write-back bypass, load-use stall with bubble insertion, and a branch flush.
- Sits between the IF stage (upstream) and EX (downstream); write-back arrives from the WB stage.

---
 rtl/id_stage_pipe_if.sv | 18 +
 rtl/id_stage_pipe.sv | 188 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: fetch-side handshake bus between the IF stage and the
// decode stage.
//   i_valid  IF presents an instruction
//   o_ready  decode stage accepts the instruction this cycle
//   i_instr  32-bit instruction word
//   i_pc     instruction PC (XLEN bits)
// master = IF side, slave = decode side.
interface id_stage_pipe_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_pc;

    modport master (output i_valid, i_instr, i_pc, input o_ready);
    modport slave  (input  i_valid, i_instr, i_pc, output o_ready);
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RISC-V decode stage with a registered ID/EX boundary.
// Decodes control, generates the immediate, reads an internal register file
// (optional write-back bypass) and holds the result in the ID/EX register.
// Handles load-use stalls with bubble insertion, EX back-pressure and flush.
// Ports:
//   i_clk, i_reset_n          clock (rising edge), async active-low reset
//   fetch (slave)             i_valid / o_ready / i_instr / i_pc from IF
//   i_flush                   kill ID/EX entry and the incoming instruction
//   i_exReady                 EX accepts the ID/EX entry
//   i_wrSig/i_wrReg/i_wrData  write-back port
//   o_valid, o_pc, o_rdData1, o_rdData2, o_immediate, o_rs1, o_rs2, o_rd,
//   o_ctrlEX {ALUop,ALUsrc,funct3,funct7}, o_ctrlMEM {Branch,MemRead,MemWrite},
//   o_ctrlWB {RegWrite,MemToReg}, o_illegal   registered ID/EX entry
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    id_stage_pipe_if.slave    fetch,
    input  logic              i_flush,
    input  logic              i_exReady,
    input  logic              i_wrSig,
    input  logic [AW-1:0]     i_wrReg,
    input  logic [XLEN-1:0]   i_wrData,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_rdData1,
    output logic [XLEN-1:0]   o_rdData2,
    output logic [XLEN-1:0]   o_immediate,
    output logic [AW-1:0]     o_rs1,
    output logic [AW-1:0]     o_rs2,
    output logic [AW-1:0]     o_rd,
    output logic [12:0]       o_ctrlEX,
    output logic [2:0]        o_ctrlMEM,
    output logic [1:0]        o_ctrlWB,
    output logic              o_illegal
);
    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    logic [XLEN-1:0] regs [NREGS];

    logic [31:0]     instr;
    opcode_e         opcode;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [1:0]      alu_op;
    logic            alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
    logic            illegal, rs1_used, rs2_used;
    logic [XLEN-1:0] imm;
    logic [12:0]     ctrl_ex;
    logic [XLEN-1:0] rd_data1, rd_data2;
    logic            adv, haz, accept;

    assign instr  = fetch.i_instr;
    assign opcode = opcode_e'(instr[6:0]);
    assign rs1    = instr[15 +: AW];
    assign rs2    = instr[20 +: AW];
    assign rd     = instr[7 +: AW];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        alu_op     = '0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        imm        = '0;
        case (opcode)
            OP_R: begin
                alu_op = 2'b10; reg_write = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_IALU: begin
                alu_op = 2'b10; alu_src = 1'b1; reg_write = 1'b1;
                rs1_used = 1'b1; imm = XLEN'($signed(imm_i));
            end
            OP_LOAD: begin
                alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
                rs1_used = 1'b1; imm = XLEN'($signed(imm_i));
            end
            OP_STORE: begin
                alu_src = 1'b1; mem_write = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1; imm = XLEN'($signed(imm_s));
            end
            OP_BRANCH: begin
                alu_op = 2'b01; branch = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1; imm = XLEN'($signed(imm_b));
            end
            OP_LUI, OP_AUIPC: begin
                alu_src = 1'b1; reg_write = 1'b1; imm = XLEN'($signed(imm_u));
            end
            OP_JAL: begin
                alu_src = 1'b1; reg_write = 1'b1; branch = 1'b1;
                imm = XLEN'($signed(imm_j));
            end
            OP_JALR: begin
                alu_src = 1'b1; reg_write = 1'b1; branch = 1'b1;
                rs1_used = 1'b1; imm = XLEN'($signed(imm_i));
            end
            default: illegal = 1'b1;
        endcase
    end

    // Unknown opcodes zero the whole control word, raw funct fields included.
    assign ctrl_ex = illegal ? '0 : {alu_op, alu_src, instr[14:12], instr[31:25]};

    always_comb begin
        rd_data1 = regs[rs1];
        rd_data2 = regs[rs2];
        if (BYPASS_EN != 0 && i_wrSig && i_wrReg == rs1) rd_data1 = i_wrData;
        if (BYPASS_EN != 0 && i_wrSig && i_wrReg == rs2) rd_data2 = i_wrData;
        if (rs1 == '0) rd_data1 = '0;
        if (rs2 == '0) rd_data2 = '0;
    end

    assign adv = !o_valid || i_exReady;
    assign haz = o_valid && o_ctrlMEM[1] && (o_rd != '0) &&
                 ((rs1_used && rs1 == o_rd) || (rs2_used && rs2 == o_rd));
    // A flush consumes the incoming instruction, so the stage is ready then too.
    assign fetch.o_ready = i_reset_n && (i_flush || (adv && !haz));
    assign accept = fetch.i_valid && fetch.o_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (i_wrSig && i_wrReg != '0) begin
            regs[i_wrReg] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_rdData1   <= '0;
            o_rdData2   <= '0;
            o_immediate <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
            o_rd        <= '0;
            o_ctrlEX    <= '0;
            o_ctrlMEM   <= '0;
            o_ctrlWB    <= '0;
            o_illegal   <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (adv && accept) begin
            o_valid     <= 1'b1;
            o_pc        <= fetch.i_pc;
            o_rdData1   <= rd_data1;
            o_rdData2   <= rd_data2;
            o_immediate <= imm;
            o_rs1       <= rs1;
            o_rs2       <= rs2;
            o_rd        <= rd;
            o_ctrlEX    <= ctrl_ex;
            o_ctrlMEM   <= {branch, mem_read, mem_write};
            o_ctrlWB    <= {reg_write, mem_to_reg};
            o_illegal   <= illegal;
        end else if (adv) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic i_clk = 1'b0;
    logic i_reset_n;
    logic i_flush, i_exReady, i_wrSig;
    logic [AW-1:0]   i_wrReg;
    logic [XLEN-1:0] i_wrData;

    logic o_valid, o_illegal;
    logic [XLEN-1:0] o_pc, o_rdData1, o_rdData2, o_immediate;
    logic [AW-1:0]   o_rs1, o_rs2, o_rd;
    logic [12:0] o_ctrlEX;
    logic [2:0]  o_ctrlMEM;
    logic [1:0]  o_ctrlWB;

    logic nb_valid, nb_illegal;
    logic [XLEN-1:0] nb_pc, nb_rdData1, nb_rdData2, nb_immediate;
    logic [AW-1:0]   nb_rs1, nb_rs2, nb_rd;
    logic [12:0] nb_ctrlEX;
    logic [2:0]  nb_ctrlMEM;
    logic [1:0]  nb_ctrlWB;

    int total = 0;
    int bad   = 0;
    logic [31:0] mreg [32];

    always #5 i_clk = ~i_clk;

    id_stage_pipe_if #(.XLEN(XLEN)) ifc ();
    id_stage_pipe_if #(.XLEN(XLEN)) ifc_nb ();

    id_stage_pipe #(.XLEN(XLEN), .NREGS(32), .BYPASS_EN(1)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .fetch(ifc),
        .i_flush(i_flush), .i_exReady(i_exReady),
        .i_wrSig(i_wrSig), .i_wrReg(i_wrReg), .i_wrData(i_wrData),
        .o_valid(o_valid), .o_pc(o_pc), .o_rdData1(o_rdData1), .o_rdData2(o_rdData2),
        .o_immediate(o_immediate), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_ctrlEX(o_ctrlEX), .o_ctrlMEM(o_ctrlMEM), .o_ctrlWB(o_ctrlWB),
        .o_illegal(o_illegal));

    id_stage_pipe #(.XLEN(XLEN), .NREGS(32), .BYPASS_EN(0)) dut_nb (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .fetch(ifc_nb),
        .i_flush(i_flush), .i_exReady(i_exReady),
        .i_wrSig(i_wrSig), .i_wrReg(i_wrReg), .i_wrData(i_wrData),
        .o_valid(nb_valid), .o_pc(nb_pc), .o_rdData1(nb_rdData1), .o_rdData2(nb_rdData2),
        .o_immediate(nb_immediate), .o_rs1(nb_rs1), .o_rs2(nb_rs2), .o_rd(nb_rd),
        .o_ctrlEX(nb_ctrlEX), .o_ctrlMEM(nb_ctrlMEM), .o_ctrlWB(nb_ctrlWB),
        .o_illegal(nb_illegal));

    // Instruction encoders: immediates are given as plain integers.
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                          logic [2:0] f3, logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(int imm, logic [4:0] s1, logic [2:0] f3,
                                          logic [4:0] d, logic [6:0] op);
        logic [31:0] t = imm;
        return {t[11:0], s1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3);
        logic [31:0] t = imm;
        return {t[11:5], s2, s1, f3, t[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int off, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3);
        logic [31:0] t = off;
        return {t[12], t[10:5], s2, s1, f3, t[4:1], t[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, logic [4:0] d, logic [6:0] op);
        logic [31:0] t = imm20;
        return {t[19:0], d, op};
    endfunction
    function automatic logic [31:0] enc_j(int off, logic [4:0] d);
        logic [31:0] t = off;
        return {t[20], t[10:1], t[11], t[19:12], d, 7'b1101111};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present(logic [31:0] ins, logic [31:0] pc);
        ifc.i_valid = 1'b1;    ifc.i_instr = ins;    ifc.i_pc = pc;
        ifc_nb.i_valid = 1'b1; ifc_nb.i_instr = ins; ifc_nb.i_pc = pc;
    endtask

    task automatic idle();
        ifc.i_valid = 1'b0;
        ifc_nb.i_valid = 1'b0;
    endtask

    task automatic wr(logic [4:0] r, logic [31:0] d);
        i_wrSig = 1'b1; i_wrReg = r; i_wrData = d;
        step();
        i_wrSig = 1'b0;
        if (r != 0) mreg[r] = d;
    endtask

    // Present, confirm acceptance, clock it into ID/EX.
    task automatic issue(logic [31:0] ins, logic [31:0] pc);
        present(ins, pc);
        #1 chk("issue_ready", {31'b0, ifc.o_ready}, 32'd1);
        step();
        idle();
    endtask

    initial begin
        logic [4:0] r, s2, d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] t;
        int imm;

        for (int i = 0; i < 32; i++) mreg[i] = '0;
        i_reset_n = 1'b0; i_flush = 1'b0; i_exReady = 1'b1;
        i_wrSig = 1'b0; i_wrReg = '0; i_wrData = '0;
        idle();
        ifc.i_instr = '0; ifc.i_pc = '0; ifc_nb.i_instr = '0; ifc_nb.i_pc = '0;

        #2;
        chk("rst_ready", {31'b0, ifc.o_ready}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_rd1", o_rdData1, 32'd0);
        chk("rst_ctrl", {14'b0, o_ctrlEX, o_ctrlMEM, o_ctrlWB}, 32'd0);
        step(); step();
        i_reset_n = 1'b1;
        #1 chk("post_rst_ready", {31'b0, ifc.o_ready}, 32'd1);

        // Basic register file and R-type decode.
        wr(5, 32'h1234);
        wr(0, 32'hFFFF);
        issue(enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd6), 32'h100);
        chk("add_valid", {31'b0, o_valid}, 32'd1);
        chk("add_rd1", o_rdData1, 32'h1234);
        chk("add_rd2", o_rdData2, 32'd0);
        chk("add_aluop", {30'b0, o_ctrlEX[12:11]}, 32'd2);
        chk("add_alusrc", {31'b0, o_ctrlEX[10]}, 32'd0);
        chk("add_wb", {30'b0, o_ctrlWB}, 32'b10);
        chk("add_mem", {29'b0, o_ctrlMEM}, 32'd0);
        chk("add_rd", {27'b0, o_rd}, 32'd6);
        chk("add_pc", o_pc, 32'h100);
        step();
        chk("bubble_valid", {31'b0, o_valid}, 32'd0);

        // Randomised R-type and I-ALU traffic against the register model.
        for (int k = 0; k < 6; k++) begin
            r  = 5'($urandom_range(1, 31));
            wr(r, $urandom);
            s2 = 5'($urandom_range(0, 31));
            d  = 5'($urandom_range(1, 31));
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            issue(enc_r(f7, s2, r, f3, d), 32'h200 + 32'(k * 8));
            chk("rnd_r_rd1", o_rdData1, mreg[r]);
            chk("rnd_r_rd2", o_rdData2, mreg[s2]);
            chk("rnd_r_ctrl", {19'b0, o_ctrlEX}, {19'b0, 2'b10, 1'b0, f3, f7});
            chk("rnd_r_rd", {27'b0, o_rd}, {27'b0, d});
            imm = int'($urandom_range(0, 4095)) - 2048;
            t = imm;
            issue(enc_i(imm, r, f3, d, 7'b0010011), 32'h204 + 32'(k * 8));
            chk("rnd_i_imm", o_immediate, t);
            chk("rnd_i_rd1", o_rdData1, mreg[r]);
            chk("rnd_i_ctrl", {19'b0, o_ctrlEX}, {19'b0, 2'b10, 1'b1, f3, t[11:5]});
        end

        // Write-back bypass in the accept cycle.
        wr(7, 32'h55);
        i_wrSig = 1'b1; i_wrReg = 5'd7; i_wrData = 32'hAA;
        present(enc_i(-1, 5'd7, 3'd0, 5'd8, 7'b0010011), 32'h280);
        step();
        i_wrSig = 1'b0;
        idle();
        mreg[7] = 32'hAA;
        chk("byp_rd1", o_rdData1, 32'hAA);
        chk("byp_imm", o_immediate, 32'hFFFFFFFF);
        chk("nobyp_rd1", nb_rdData1, 32'h55);

        // Load-use hazard: exactly one stall cycle.
        wr(1, 32'h1000);
        wr(2, 32'h22);
        issue(enc_i(0, 5'd1, 3'd2, 5'd3, 7'b0000011), 32'h300);
        chk("lw_mem", {29'b0, o_ctrlMEM}, 32'b010);
        chk("lw_wb", {30'b0, o_ctrlWB}, 32'b11);
        present(enc_r(7'd0, 5'd2, 5'd3, 3'd0, 5'd4), 32'h304);
        #1 chk("lu_stall_ready", {31'b0, ifc.o_ready}, 32'd0);
        step();
        chk("lu_bubble", {31'b0, o_valid}, 32'd0);
        chk("lu_ready_again", {31'b0, ifc.o_ready}, 32'd1);
        step();
        idle();
        chk("lu_issue_valid", {31'b0, o_valid}, 32'd1);
        chk("lu_issue_rd", {27'b0, o_rd}, 32'd4);
        chk("lu_issue_rd2", o_rdData2, mreg[2]);

        // Load followed by an independent instruction: no stall.
        issue(enc_i(0, 5'd1, 3'd2, 5'd3, 7'b0000011), 32'h310);
        issue(enc_i(1, 5'd9, 3'd0, 5'd4, 7'b0010011), 32'h314);
        chk("nolu_valid", {31'b0, o_valid}, 32'd1);
        chk("nolu_imm", o_immediate, 32'd1);
        chk("nolu_rs1", {27'b0, o_rs1}, 32'd9);

        // EX back-pressure.
        issue(enc_i(5, 5'd5, 3'd0, 5'd10, 7'b0010011), 32'h3FC);
        i_exReady = 1'b0;
        present(enc_i(6, 5'd5, 3'd0, 5'd11, 7'b0010011), 32'h400);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", {31'b0, ifc.o_ready}, 32'd0);
            step();
            chk("bp_valid", {31'b0, o_valid}, 32'd1);
            chk("bp_rd", {27'b0, o_rd}, 32'd10);
            chk("bp_pc", o_pc, 32'h3FC);
            chk("bp_imm", o_immediate, 32'd5);
        end
        i_exReady = 1'b1;
        #1 chk("bp_release_ready", {31'b0, ifc.o_ready}, 32'd1);
        step();
        idle();
        chk("bp_next_rd", {27'b0, o_rd}, 32'd11);
        chk("bp_next_pc", o_pc, 32'h400);

        // Flush kills the entry and the incoming instruction.
        present(enc_i(7, 5'd5, 3'd0, 5'd12, 7'b0010011), 32'h404);
        i_flush = 1'b1;
        #1 chk("fl_ready", {31'b0, ifc.o_ready}, 32'd1);
        step();
        i_flush = 1'b0;
        idle();
        chk("fl_valid", {31'b0, o_valid}, 32'd0);
        step();
        chk("fl_not_issued", {31'b0, o_valid}, 32'd0);

        // Immediate formats and illegal opcode.
        issue(enc_b(-4, 5'd2, 5'd1, 3'd0), 32'h500);
        chk("beq_imm", o_immediate, 32'hFFFFFFFC);
        chk("beq_mem", {29'b0, o_ctrlMEM}, 32'b100);
        chk("beq_aluop", {30'b0, o_ctrlEX[12:11]}, 32'd1);
        issue(enc_j(32'h800, 5'd1), 32'h504);
        chk("jal_imm", o_immediate, 32'h800);
        chk("jal_mem", {29'b0, o_ctrlMEM}, 32'b100);
        chk("jal_wb", {30'b0, o_ctrlWB}, 32'b10);
        issue(enc_s(-8, 5'd2, 5'd1, 3'd2), 32'h508);
        chk("sw_imm", o_immediate, 32'hFFFFFFF8);
        chk("sw_mem", {29'b0, o_ctrlMEM}, 32'b001);
        chk("sw_wb", {30'b0, o_ctrlWB}, 32'b00);
        issue(enc_u(32'hABCDE, 5'd5, 7'b0110111), 32'h50C);
        chk("lui_imm", o_immediate, 32'hABCDE000);
        issue(32'h0000007F, 32'h510);
        chk("ill_flag", {31'b0, o_illegal}, 32'd1);
        chk("ill_valid", {31'b0, o_valid}, 32'd1);
        chk("ill_ctrl", {14'b0, o_ctrlEX, o_ctrlMEM, o_ctrlWB}, 32'd0);

        // Reset asserted during a load-use stall.
        issue(enc_i(0, 5'd1, 3'd2, 5'd3, 7'b0000011), 32'h600);
        present(enc_r(7'd0, 5'd2, 5'd3, 3'd0, 5'd4), 32'h604);
        #1 chk("rs_stall_ready", {31'b0, ifc.o_ready}, 32'd0);
        i_reset_n = 1'b0;
        #1;
        chk("rs_valid", {31'b0, o_valid}, 32'd0);
        chk("rs_ready", {31'b0, ifc.o_ready}, 32'd0);
        step();
        idle();
        i_reset_n = 1'b1;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        #1;
        chk("rs_after_valid", {31'b0, o_valid}, 32'd0);
        step();
        chk("rs_no_retain", {31'b0, o_valid}, 32'd0);
        issue(enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd6), 32'h700);
        chk("rs_regfile_clear", o_rdData1, mreg[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
